// File: rtl/clock_ratio_scheduler.sv
// clock_ratio_scheduler
// Time-shares one saturating tick counter across NUM_CH monitored clocks.
// For each channel in turn it settles for WARMUP cycles and counts ch_tick
// over WINDOW cycles. It then compares the count with exp_cnt within +/-tol
// and records a pass flag.
// Ports:
//   aclk, rst        clock, synchronous active-high reset
//   start            one-cycle pulse, begins a sweep when idle or done
//   ch_tick          per-channel edge pulses, aclk-synchronous
//   exp_cnt, tol     expected ticks per window (ch i at [i*CNT_W+:CNT_W]), tolerance
//   busy, done       sweep in progress / sweep complete (level)
//   same             per-channel pass flags of the last sweep
//   meas_valid       one-cycle strobe per COMPARE cycle with meas_ch/meas_cnt
module clock_ratio_scheduler #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned WARMUP = 100,
    parameter int unsigned WINDOW = 1024
) (
    input  logic                                        aclk,
    input  logic                                        rst,
    input  logic                                        start,
    input  logic [NUM_CH-1:0]                           ch_tick,
    input  logic [NUM_CH*CNT_W-1:0]                     exp_cnt,
    input  logic [CNT_W-1:0]                            tol,
    output logic                                        busy,
    output logic                                        done,
    output logic [NUM_CH-1:0]                           same,
    output logic                                        meas_valid,
    output logic [(NUM_CH > 1 ? $clog2(NUM_CH) : 1)-1:0] meas_ch,
    output logic [CNT_W-1:0]                            meas_cnt
);

    localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned TMR_MX = (WARMUP > WINDOW) ? WARMUP : WINDOW;
    localparam int unsigned TMR_W  = $clog2(TMR_MX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        MEASURE = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_CH-1:0]  same_q, same_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               meas_valid_q, meas_valid_d;
    logic [CH_W-1:0]    meas_ch_q, meas_ch_d;
    logic [CNT_W-1:0]   meas_cnt_q, meas_cnt_d;

    // Tolerance check of the final count (held in cnt_q during COMPARE)
    logic [CNT_W-1:0]   exp_sel_c;
    logic [CNT_W:0]     diff_c;
    logic               pass_c;

    assign exp_sel_c = exp_cnt[int'(ch_q)*CNT_W +: CNT_W];
    assign diff_c    = (cnt_q >= exp_sel_c) ? ({1'b0, cnt_q} - {1'b0, exp_sel_c})
                                            : ({1'b0, exp_sel_c} - {1'b0, cnt_q});
    assign pass_c    = (diff_c <= {1'b0, tol});

    // Next-state and registered-output logic
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        tmr_d        = tmr_q;
        cnt_d        = cnt_q;
        same_d       = same_q;
        meas_valid_d = 1'b0;
        meas_ch_d    = meas_ch_q;
        meas_cnt_d   = meas_cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = SETTLE;
                    ch_d    = '0;
                    tmr_d   = '0;
                    cnt_d   = '0;
                    same_d  = '0;
                end
            end
            SETTLE: begin
                cnt_d = '0;
                if (tmr_q == TMR_W'(WARMUP - 1)) begin
                    state_d = MEASURE;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            MEASURE: begin
                // Saturating count; the last window cycle's tick is included
                if (ch_tick[ch_q] && (cnt_q != {CNT_W{1'b1}})) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (tmr_q == TMR_W'(WINDOW - 1)) begin
                    state_d      = COMPARE;
                    tmr_d        = '0;
                    meas_valid_d = 1'b1;
                    meas_ch_d    = ch_q;
                    meas_cnt_d   = cnt_d;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            COMPARE: begin
                same_d[ch_q] = pass_c;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    state_d = DONE;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == COMPARE);
        done_d = (state_d == DONE);
    end

    // State and output registers
    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            tmr_q        <= '0;
            cnt_q        <= '0;
            same_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            meas_valid_q <= 1'b0;
            meas_ch_q    <= '0;
            meas_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            tmr_q        <= tmr_d;
            cnt_q        <= cnt_d;
            same_q       <= same_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            meas_valid_q <= meas_valid_d;
            meas_ch_q    <= meas_ch_d;
            meas_cnt_q   <= meas_cnt_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign same       = same_q;
    assign meas_valid = meas_valid_q;
    assign meas_ch    = meas_ch_q;
    assign meas_cnt   = meas_cnt_q;

endmodule

// File: tb/tb_clock_ratio_scheduler.sv
// Testbench for clock_ratio_scheduler (NUM_CH=2, CNT_W=8, WARMUP=4, WINDOW=16).
module tb_clock_ratio_scheduler;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned WARMUP = 4;
    localparam int unsigned WINDOW = 16;
    localparam int          DONE_CYC = 1 + NUM_CH * (WARMUP + WINDOW + 1);

    logic                      aclk = 1'b0;
    logic                      rst;
    logic                      start;
    logic [NUM_CH-1:0]         ch_tick;
    logic [NUM_CH*CNT_W-1:0]   exp_cnt;
    logic [CNT_W-1:0]          tol;
    logic                      busy;
    logic                      done;
    logic [NUM_CH-1:0]         same;
    logic                      meas_valid;
    logic [0:0]                meas_ch;
    logic [CNT_W-1:0]          meas_cnt;

    clock_ratio_scheduler #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WARMUP(WARMUP), .WINDOW(WINDOW)
    ) dut (
        .aclk(aclk), .rst(rst), .start(start), .ch_tick(ch_tick),
        .exp_cnt(exp_cnt), .tol(tol), .busy(busy), .done(done), .same(same),
        .meas_valid(meas_valid), .meas_ch(meas_ch), .meas_cnt(meas_cnt)
    );

    always #5 aclk = ~aclk;

    // mode 0: channel i ticks when cyc % p_i == 0 (p_i == 0: never)
    // mode 1: ticks only in SETTLE windows and on the non-selected channel
    typedef struct {
        int mode;
        int p0, p1;
        int e0, e1;
        int tl;
        int restart;     // cycle of an extra start while busy, 0 = none
        int exp_same;
    } vec_t;

    typedef struct {
        int ch;
        int cnt;
    } sb_t;

    sb_t sb[$];
    int  n_checks = 0;
    int  n_fails  = 0;
    int  last_cnt;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fails++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] tick_fn(input int cyc, input vec_t v);
        logic [1:0] t;
        t = 2'b00;
        if (v.mode == 0) begin
            if (v.p0 != 0 && (cyc % v.p0) == 0) t[0] = 1'b1;
            if (v.p1 != 0 && (cyc % v.p1) == 0) t[1] = 1'b1;
        end else begin
            if ((cyc >= 1 && cyc <= 4) || (cyc >= 22 && cyc <= 25)) t = 2'b11;
            else if (cyc >= 5 && cyc <= 20)                          t = 2'b10;
            else if (cyc >= 26 && cyc <= 41)                         t = 2'b01;
        end
        return t;
    endfunction

    function automatic int model_cnt(input int mode, input int p);
        if (mode != 0 || p == 0) return 0;
        return int'(WINDOW) / p;
    endfunction

    task automatic load_vec(input vec_t v);
        sb_t e;
        exp_cnt = {CNT_W'(v.e1), CNT_W'(v.e0)};
        tol     = CNT_W'(v.tl);
        sb.delete();
        e.ch = 0; e.cnt = model_cnt(v.mode, v.p0); sb.push_back(e);
        e.ch = 1; e.cnt = model_cnt(v.mode, v.p1); sb.push_back(e);
        last_cnt = e.cnt;
    endtask

    task automatic check_strobe(input string tag);
        sb_t e;
        if (meas_valid) begin
            if (sb.size() == 0) begin
                chk({tag, " unexpected strobe"}, 1, 0);
            end else begin
                e = sb.pop_front();
                chk({tag, " meas_ch"},  int'(meas_ch),  e.ch);
                chk({tag, " meas_cnt"}, int'(meas_cnt), e.cnt);
            end
        end
    endtask

    // Full sweep: start at cycle 0, check timing, strobes and final flags
    task automatic run_vec(input vec_t v, input string tag);
        int cyc;
        load_vec(v);
        start   = 1'b1;
        ch_tick = tick_fn(0, v);
        @(posedge aclk); #1;
        cyc = 1;
        while (cyc <= DONE_CYC) begin
            check_strobe(tag);
            if (cyc == 1) begin
                chk({tag, " busy@1"}, int'(busy), 1);
                chk({tag, " done@1"}, int'(done), 0);
                chk({tag, " same@1"}, int'(same), 0);
            end
            if (cyc == DONE_CYC - 1) begin
                chk({tag, " done@42"}, int'(done), 0);
                chk({tag, " busy@42"}, int'(busy), 1);
            end
            if (cyc == DONE_CYC) begin
                chk({tag, " done@43"}, int'(done), 1);
                chk({tag, " busy@43"}, int'(busy), 0);
                chk({tag, " same"}, int'(same), v.exp_same);
                chk({tag, " meas_ch hold"}, int'(meas_ch), 1);
                chk({tag, " meas_cnt hold"}, int'(meas_cnt), last_cnt);
                chk({tag, " strobes left"}, sb.size(), 0);
                break;
            end
            start   = (v.restart != 0 && cyc == v.restart);
            ch_tick = tick_fn(cyc, v);
            @(posedge aclk); #1;
            cyc++;
        end
        start   = 1'b0;
        ch_tick = '0;
    endtask

    vec_t vecs[7];
    vec_t v_rst;

    initial begin
        int cyc;
        int strobes;

        //        mode p0 p1  e0   e1  tol restart same
        vecs[0] = '{0, 2, 4,   8,   4, 1, 10, 2'b11};
        vecs[1] = '{0, 2, 1,   8,   4, 1,  0, 2'b01};
        vecs[2] = '{0, 2, 2,   9,  10, 1,  0, 2'b01};
        vecs[3] = '{0, 2, 2,   8,   7, 0,  0, 2'b01};
        vecs[4] = '{1, 0, 0,   0,   1, 0,  0, 2'b01};
        vecs[5] = '{0, 1, 0, 255,   0, 1,  0, 2'b01 << 1};
        vecs[6] = '{0, 0, 1, 200,   0, 255, 0, 2'b11};

        rst = 1'b1; start = 1'b0; ch_tick = '0; exp_cnt = '0; tol = '0;
        repeat (3) @(posedge aclk);
        #1;
        chk("reset busy",       int'(busy),       0);
        chk("reset done",       int'(done),       0);
        chk("reset same",       int'(same),       0);
        chk("reset meas_valid", int'(meas_valid), 0);
        chk("reset meas_ch",    int'(meas_ch),    0);
        chk("reset meas_cnt",   int'(meas_cnt),   0);
        rst = 1'b0;
        @(posedge aclk); #1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a sweep, after ch0 has already passed
        v_rst = vecs[0];
        v_rst.restart = 0;
        load_vec(v_rst);
        start   = 1'b1;
        ch_tick = tick_fn(0, v_rst);
        @(posedge aclk); #1;
        start = 1'b0;
        for (cyc = 1; cyc <= 25; cyc++) begin
            check_strobe("rst_seq");
            if (cyc == 25) begin
                chk("rst_seq same@25", int'(same), 2'b01);
                rst = 1'b1;
            end
            ch_tick = tick_fn(cyc, v_rst);
            @(posedge aclk); #1;
        end
        rst = 1'b0;
        chk("rst_seq busy@26",       int'(busy),       0);
        chk("rst_seq done@26",       int'(done),       0);
        chk("rst_seq same@26",       int'(same),       0);
        chk("rst_seq meas_valid@26", int'(meas_valid), 0);
        chk("rst_seq meas_cnt@26",   int'(meas_cnt),   0);
        strobes = 0;
        for (cyc = 27; cyc <= 60; cyc++) begin
            ch_tick = tick_fn(cyc, v_rst);
            @(posedge aclk); #1;
            if (meas_valid || busy) strobes++;
        end
        ch_tick = '0;
        chk("rst_seq idle after reset", strobes, 0);

        run_vec(v_rst, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
